uart_monitor: RTL and testbench
===============================

# uart_monitor

Serial debug/load monitor: the host-side end of the UART link. It consumes received bytes from the UART byte interface, decodes host command packets, performs 32-bit memory reads and writes on the system memory bus, and sends responses back through the UART transmitter. It sits between the UART byte ports and a memory-bus arbiter port, so a PC can load and inspect RAM without CPU involvement.

## Interface
- `TIMEOUT`, 1000000, inter-byte timeout in clk cycles inside a packet; 0 disables the timeout
- `clk` input 1: system clock
- `resetn` input 1: asynchronous active-low reset
- `rx_data` input 8: received byte; valid while `rx_valid` is high
- `rx_valid` input 1: one-cycle strobe, a new byte is on `rx_data`
- `tx_data` output 8: byte to transmit; held stable from `tx_start` until `tx_busy` falls
- `tx_start` output 1: one-cycle transmit request
- `tx_busy` input 1: transmitter busy; rises the cycle after `tx_start`
- `mem_valid` output 1: bus request; held until `mem_ready`
- `mem_ready` input 1: bus completion; read data valid in the same cycle
- `mem_addr` output 32: word address, bits [1:0] forced 0
- `mem_wdata` output 32: write data
- `mem_wstrb` output 4: 4'hF for write, 4'h0 for read
- `mem_rdata` input 32: read data
- `err` output 1: sticky; set on NAK or timeout, cleared only by reset

## Operation
- Packet formats, all multi-byte fields LSB first:
  - Write: 0x57 ('W'), addr[4], data[4]; reply 0x06 (ACK) after `mem_ready`
  - Read: 0x52 ('R'), addr[4]; reply data[4] after `mem_ready`
  - Any other command byte: reply 0x15 (NAK), return to IDLE
- States: IDLE, ADDR, DATA, CSUM, MEM, RESP, RESP_WAIT.
  - IDLE -> ADDR on a valid command byte.
  - ADDR collects 4 bytes. W: -> DATA. R: -> CSUM if checksum is enabled, else MEM.
  - DATA collects 4 bytes -> CSUM if checksum is enabled, else MEM.
  - MEM asserts `mem_valid` until `mem_ready` -> RESP.
  - RESP pulses `tx_start` -> RESP_WAIT.
  - RESP_WAIT ignores `tx_busy` in its first cycle, then waits for `tx_busy` low. It then goes -> RESP for the next response byte, or -> IDLE after the last byte.
- Byte counter is 2 bits; it wraps 3 -> 0 on the field's last byte, and that byte triggers the state advance.
- `rx_valid` in MEM, RESP or RESP_WAIT: byte discarded, no other effect.
- Timeout: in ADDR/DATA/CSUM, the counter is cleared on every `rx_valid`. When it reaches `TIMEOUT`, go -> IDLE silently, set `err`, no bus cycle. The counter is held at 0 in the other states.
- `mem_valid` and `mem_ready` high on the same cycle count as one transfer; `mem_valid` drops the next cycle.
- Reset mid-operation: all state is abandoned immediately, including during an in-flight bus cycle (`mem_valid` deasserts) or a pending transmit.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `err`=0, state IDLE.
- All outputs are registered.
- `mem_valid` rises the cycle after the final packet byte's `rx_valid`.
- `tx_start` rises the cycle after `mem_ready` (or after the bad command byte for NAK).
- Between consecutive read-response bytes: `tx_start` pulses one cycle after `tx_busy` is sampled low.

## Configuration
- `UART_MONITOR_CHECKSUM_EN` defined:
  - W and R packets carry one trailing byte: 8-bit sum, modulo 256, of every preceding packet byte including the command.
  - Mismatch: reply NAK, set `err`, no bus cycle.
  - The timeout also applies in CSUM.
- Undefined: no CSUM state, no checksum byte; packets are exactly as listed in Operation.

## Test plan
- Write (no checksum): bytes 57 10 00 00 00 EF BE AD DE -> one bus cycle, addr 0x00000010, wdata 0xDEADBEEF, wstrb F; then reply 06.
- Read: bytes 52 10 00 00 00, `mem_rdata`=0x12345678 with `mem_ready` delayed 5 cycles -> `mem_valid` held 6 cycles, wstrb 0; replies 78 56 34 12, each `tx_start` only after `tx_busy` falls.
- Bad command 0x41 -> reply 15, `err`=1, no `mem_valid`; a following valid read still succeeds.
- Timeout with `TIMEOUT`=100: send 57 11 22, then idle 101 cycles -> return to IDLE, `err`=1, no bus cycle; a subsequent full write works.
- With `UART_MONITOR_CHECKSUM_EN`: read 52 04 00 00 00 with checksum 56 -> normal reply. Same packet with checksum 57 -> reply 15, no bus cycle.
- Assert `resetn` low during MEM and during RESP_WAIT -> all outputs at reset values asynchronously; the next packet decodes normally.

Source files
------------

// File: rtl/uart_monitor.sv
`default_nettype none
// ============================================================================
// Module      : uart_monitor
// Description : Host-side serial debug/load monitor. Decodes command packets
//               arriving on the UART byte interface, runs one 32-bit read or
//               write on the system memory bus per packet and returns the
//               response through the UART transmitter.
//
//               Packets (multi-byte fields LSB first):
//                 'W' 0x57, addr[4], data[4]  -> reply 0x06 after the write
//                 'R' 0x52, addr[4]           -> reply data[4] after the read
//                 anything else               -> reply 0x15 (NAK)
//
//               Optional build macro UART_MONITOR_CHECKSUM_EN: every W/R
//               packet carries a trailing 8-bit sum of all preceding packet
//               bytes; a mismatch answers NAK with no bus cycle.
//
// Parameters  : TIMEOUT   inter-byte timeout in clk cycles (0 disables)
// Ports       : clk, resetn          clock, async active-low reset
//               rx_data, rx_valid    received byte + one-cycle strobe
//               tx_data, tx_start    byte to send + one-cycle request
//               tx_busy              transmitter busy
//               mem_valid/mem_ready  bus request / completion
//               mem_addr, mem_wdata  word address, write data
//               mem_wstrb, mem_rdata write strobes, read data
//               err                  sticky NAK/timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module uart_monitor #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam logic [7:0]  c_cmd_write = 8'h57;
  localparam logic [7:0]  c_cmd_read  = 8'h52;
  localparam logic [7:0]  c_ack       = 8'h06;
  localparam logic [7:0]  c_nak       = 8'h15;
  localparam logic [31:0] c_timeout   = TIMEOUT;
  localparam logic        c_tmo_en    = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_DATA      = 3'd2,
    S_MEM       = 3'd3,
    S_RESP      = 3'd4,
`ifdef UART_MONITOR_CHECKSUM_EN
    S_RESP_WAIT = 3'd5,
    S_CSUM      = 3'd6
`else
    S_RESP_WAIT = 3'd5
`endif
  } state_t;

  // State entered once the last address/data field of a packet is complete.
`ifdef UART_MONITOR_CHECKSUM_EN
  localparam state_t c_after_payload = S_CSUM;
`else
  localparam state_t c_after_payload = S_MEM;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;       // byte index inside the current 4-byte field
  logic        r_is_write;
  logic [23:0] r_rdata;     // read-response bytes still to be sent
  logic [1:0]  r_left;      // response bytes remaining after the current one
  logic        r_first;     // first cycle of RESP_WAIT: tx_busy not yet valid
  logic [31:0] r_tmo;
`ifdef UART_MONITOR_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  logic        w_nak;
  logic        w_tmo_err;
  logic        w_tmo_hit;
  logic        w_last;
  logic        w_collect;

  always_comb begin
    w_next    = r_state;
    w_nak     = 1'b0;
    w_tmo_err = 1'b0;
    w_collect = 1'b0;
    w_last    = rx_valid && (r_cnt == 2'd3);
    w_tmo_hit = c_tmo_en && !rx_valid && (r_tmo == c_timeout);
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == c_cmd_write || rx_data == c_cmd_read) begin
            w_next = S_ADDR;
          end else begin
            w_next = S_RESP;
            w_nak  = 1'b1;
          end
        end
      end
      S_ADDR: begin
        w_collect = 1'b1;
        if (w_last) begin
          w_next = r_is_write ? S_DATA : c_after_payload;
        end else if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_tmo_err = 1'b1;
        end
      end
      S_DATA: begin
        w_collect = 1'b1;
        if (w_last) begin
          w_next = c_after_payload;
        end else if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_tmo_err = 1'b1;
        end
      end
`ifdef UART_MONITOR_CHECKSUM_EN
      S_CSUM: begin
        w_collect = 1'b1;
        if (rx_valid) begin
          if (rx_data == r_sum) begin
            w_next = S_MEM;
          end else begin
            w_next = S_RESP;
            w_nak  = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_tmo_err = 1'b1;
        end
      end
`endif
      S_MEM: begin
        if (mem_ready) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_RESP_WAIT;
      end
      S_RESP_WAIT: begin
        if (!r_first && !tx_busy) begin
          w_next = (r_left == 2'd0) ? S_IDLE : S_RESP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so that mem_valid and
  // tx_start appear exactly one cycle after the triggering event.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_is_write <= 1'b0;
      r_rdata    <= 24'h0;
      r_left     <= 2'd0;
      r_first    <= 1'b0;
      r_tmo      <= 32'd0;
`ifdef UART_MONITOR_CHECKSUM_EN
      r_sum      <= 8'h00;
`endif
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
      err        <= 1'b0;
    end else begin
      r_state   <= w_next;
      mem_valid <= (w_next == S_MEM);
      mem_wstrb <= ((w_next == S_MEM) && r_is_write) ? 4'hF : 4'h0;
      tx_start  <= (w_next == S_RESP);
      r_first   <= (r_state == S_RESP);

      if (w_nak || w_tmo_err) begin
        err <= 1'b1;
      end

      // Idle-time counter: runs only while waiting for packet bytes.
      if (w_collect && c_tmo_en && !rx_valid && (w_next == r_state)) begin
        r_tmo <= r_tmo + 32'd1;
      end else begin
        r_tmo <= 32'd0;
      end

      if (w_nak) begin
        tx_data <= c_nak;
        r_left  <= 2'd0;
      end

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_is_write <= (rx_data == c_cmd_write);
            r_cnt      <= 2'd0;
`ifdef UART_MONITOR_CHECKSUM_EN
            r_sum      <= rx_data;
`endif
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            // Shift in LSB first; the low two address bits are kept at zero.
            mem_addr <= {rx_data, mem_addr[31:10], 2'b00};
            r_cnt    <= r_cnt + 2'd1;
`ifdef UART_MONITOR_CHECKSUM_EN
            r_sum    <= r_sum + rx_data;
`endif
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            mem_wdata <= {rx_data, mem_wdata[31:8]};
            r_cnt     <= r_cnt + 2'd1;
`ifdef UART_MONITOR_CHECKSUM_EN
            r_sum     <= r_sum + rx_data;
`endif
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (r_is_write) begin
              tx_data <= c_ack;
              r_left  <= 2'd0;
            end else begin
              tx_data <= mem_rdata[7:0];
              r_rdata <= mem_rdata[31:8];
              r_left  <= 2'd3;
            end
          end
        end
        S_RESP_WAIT: begin
          if (w_next == S_RESP) begin
            tx_data <= r_rdata[7:0];
            r_rdata <= {8'h00, r_rdata[23:8]};
            r_left  <= r_left - 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_monitor
// Description : Scoreboard bench for uart_monitor. Stimulus tasks push the
//               expected bus transfers and transmit bytes into queues; a
//               negedge monitor models the memory slave and the UART
//               transmitter and pops/compares as the DUT produces output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_monitor;

  localparam int c_busy_cycles = 6;
  localparam int c_wait_limit  = 3000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } bus_t;

  // kind: 0 = first byte after a bus transfer, 1 = follow-on read byte,
  //       2 = NAK answering the last received byte
  typedef struct {
    logic [7:0] data;
    int         kind;
  } tx_t;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy   = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bus_t       exp_bus[$];
  tx_t        exp_tx[$];
  logic [7:0] pkt[$];

  int         mem_delay   = 0;
  int         last_rx_cyc = 0;
  int         hs_cyc      = 0;
  int         fall_cyc    = 0;
  int         mv_cnt      = 0;
  int         bcnt        = 0;
  logic [7:0] held        = 8'h00;
  bus_t       mb;
  tx_t        mt;

  uart_monitor #(.TIMEOUT(100)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory slave and UART transmitter models plus output comparison.
  always @(negedge clk) begin
    if (!resetn) begin
      mem_ready = 1'b0;
      tx_busy   = 1'b0;
      mv_cnt    = 0;
      bcnt      = 0;
    end else begin
      if (mem_ready) begin
        check_eq("mem_valid_drop", mem_valid, 1'b0);
        mem_ready = 1'b0;
        mv_cnt    = 0;
      end else if (mem_valid) begin
        if (mv_cnt == 0) begin
          if (exp_bus.size() == 0) check_eq("bus_unexpected", 1, 0);
          else check_eq("mem_valid_rise_cyc", cyc, last_rx_cyc + 1);
        end
        mv_cnt++;
        if (exp_bus.size() == 0) begin
          mem_ready = 1'b1;
        end else if (mv_cnt == mem_delay + 1) begin
          mb = exp_bus.pop_front();
          check_eq("mem_addr", mem_addr, mb.addr);
          check_eq("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, mb.wstrb});
          if (mb.wstrb == 4'hF) check_eq("mem_wdata", mem_wdata, mb.wdata);
          mem_rdata = mb.rdata;
          mem_ready = 1'b1;
          hs_cyc    = cyc;
        end
      end else if (mv_cnt > 0) begin
        check_eq("mem_valid_early_drop", 1, 0);
        mv_cnt = 0;
      end

      if (tx_start) begin
        check_eq("tx_start_while_busy", tx_busy, 1'b0);
        if (exp_tx.size() == 0) begin
          check_eq("tx_unexpected", 1, 0);
        end else begin
          mt = exp_tx.pop_front();
          check_eq("tx_data", {24'h0, tx_data}, {24'h0, mt.data});
          case (mt.kind)
            0:       check_eq("tx_after_bus_cyc", cyc, hs_cyc + 1);
            1:       check_eq("tx_after_busy_cyc", cyc, fall_cyc + 1);
            default: check_eq("tx_after_nak_cyc", cyc, last_rx_cyc + 1);
          endcase
        end
        held    = tx_data;
        tx_busy = 1'b1;
        bcnt    = c_busy_cycles;
      end else if (tx_busy) begin
        check_eq("tx_data_hold", {24'h0, tx_data}, {24'h0, held});
        bcnt--;
        if (bcnt == 0) begin
          tx_busy  = 1'b0;
          fall_cyc = cyc;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data     = b;
    rx_valid    = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pkt.push_back(w[8*i +: 8]);
  endtask

  task automatic send_pkt(input bit add_csum);
    logic [7:0] sum;
    sum = 8'h00;
    foreach (pkt[i]) begin
      send_byte(pkt[i]);
      sum = sum + pkt[i];
    end
`ifdef UART_MONITOR_CHECKSUM_EN
    if (add_csum) send_byte(sum);
`else
    if (add_csum) sum = 8'h00;
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || tx_busy) && n < c_wait_limit) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("wait_idle_expired", (n >= c_wait_limit), 0);
    check_eq("bus_left", exp_bus.size(), 0);
    check_eq("tx_left", exp_tx.size(), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    mem_delay = 0;
    exp_bus.push_back('{addr: {a[31:2], 2'b00}, wdata: d, wstrb: 4'hF, rdata: 32'h0});
    exp_tx.push_back('{data: 8'h06, kind: 0});
    pkt.delete();
    pkt.push_back(8'h57);
    push_word(a);
    push_word(d);
    send_pkt(1'b1);
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input int dly);
    mem_delay = dly;
    exp_bus.push_back('{addr: {a[31:2], 2'b00}, wdata: 32'h0, wstrb: 4'h0, rdata: rd});
    for (int i = 0; i < 4; i++) exp_tx.push_back('{data: rd[8*i +: 8], kind: (i == 0) ? 0 : 1});
    pkt.delete();
    pkt.push_back(8'h52);
    push_word(a);
    send_pkt(1'b1);
    // A byte arriving during the bus cycle must be ignored.
    if (dly >= 4) send_byte(8'h57);
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_tx_start", tx_start, 1'b0);
    check_eq("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check_eq("rst_mem_valid", mem_valid, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check_eq("rst_err", err, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_bus.delete();
    exp_tx.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    do_reset();
    check_reset_outputs();

    // Basic write and delayed read
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    check_eq("err_after_write", err, 1'b0);
    do_read(32'h0000_0010, 32'h1234_5678, 5);
    do_write(32'h0000_1003, 32'hA5A5_0F0F);
    do_read(32'h8000_0ffc, 32'h0BAD_F00D, 0);
    check_eq("err_after_ops", err, 1'b0);

    // Bad command: NAK, sticky err, then a normal read
    exp_tx.push_back('{data: 8'h15, kind: 2});
    send_byte(8'h41);
    wait_idle();
    check_eq("err_after_nak", err, 1'b1);
    do_read(32'h0000_0020, 32'hCAFE_F00D, 2);
    check_eq("err_sticky", err, 1'b1);

    // Inter-byte timeout
    do_reset();
    pkt.delete();
    pkt.push_back(8'h57);
    pkt.push_back(8'h11);
    pkt.push_back(8'h22);
    send_pkt(1'b0);
    repeat (101) @(negedge clk);
    check_eq("err_after_timeout", err, 1'b1);
    check_eq("no_bus_after_timeout", mem_valid, 1'b0);
    do_write(32'h0000_0044, 32'h0102_0304);

`ifdef UART_MONITOR_CHECKSUM_EN
    do_reset();
    do_read(32'h0000_0004, 32'h5566_7788, 1);
    check_eq("err_csum_good", err, 1'b0);
    exp_tx.push_back('{data: 8'h15, kind: 2});
    pkt.delete();
    pkt.push_back(8'h52);
    push_word(32'h0000_0004);
    pkt.push_back(8'h57);
    send_pkt(1'b0);
    wait_idle();
    check_eq("err_csum_bad", err, 1'b1);
`endif

    // Reset while the bus cycle is in flight
    do_reset();
    mem_delay = 40;
    exp_bus.push_back('{addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0});
    pkt.delete();
    pkt.push_back(8'h52);
    push_word(32'h0000_0100);
    send_pkt(1'b1);
    n = 0;
    while (!mem_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("mem_valid_seen_expired", (n >= 200), 0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_outputs();
    exp_bus.delete();
    exp_tx.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    do_read(32'h0000_0200, 32'h8765_4321, 3);

    // Reset while waiting on the transmitter
    exp_bus.push_back('{addr: 32'h0000_0300, wdata: 32'h1111_2222, wstrb: 4'hF, rdata: 32'h0});
    exp_tx.push_back('{data: 8'h06, kind: 0});
    mem_delay = 0;
    pkt.delete();
    pkt.push_back(8'h57);
    push_word(32'h0000_0300);
    push_word(32'h1111_2222);
    send_pkt(1'b1);
    n = 0;
    while (!tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("tx_busy_seen_expired", (n >= 200), 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_outputs();
    exp_bus.delete();
    exp_tx.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    do_write(32'h0000_0400, 32'h3333_4444);
    check_eq("err_final", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
